maze_sched: RTL
===============

MAZE_SCHED -- requirements
Module: maze_sched

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: single clock; all logic on rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port `req`, input, 2 bits: per-requester job request; held high until granted.
REQ-004 The block SHALL have the port `maze0`, input, 225 bits: requester 0 maze; bit y*15+x = cell (x,y); 1 = wall.
REQ-005 The block SHALL have the port `maze1`, input, 225 bits: requester 1 maze, same encoding.
REQ-006 The block SHALL have the port `grant`, output, 2 bits: one-hot, 1-cycle pulse when a job is accepted.
REQ-007 The block SHALL have the port `busy`, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have the port `slv_rst`, output, 1 bit: reset request to the shared solver.
REQ-009 The block SHALL have the port `slv_in_valid`, output, 1 bit: solver input strobe.
REQ-010 The block SHALL have the port `slv_maze`, output, 1 bit: serial maze bit to the solver.
REQ-011 The block SHALL have the port `slv_out_valid`, input, 1 bit: solver path-coordinate strobe.
REQ-012 The block SHALL have the port `slv_not_valid`, input, 1 bit: solver "no path" pulse.
REQ-013 The block SHALL have the port `slv_out_x`, input, 4 bits: solver path x.
REQ-014 The block SHALL have the port `slv_out_y`, input, 4 bits: solver path y.
REQ-015 The block SHALL have the port `rsp_valid`, output, 1 bit: forwarded coordinate valid.
REQ-016 The block SHALL have the port `rsp_id`, output, 1 bit: owning requester of the current job.
REQ-017 The block SHALL have the port `rsp_x`, output, 4 bits, and the port `rsp_y`, output, 4 bits: forwarded coordinates.
REQ-018 The block SHALL have the port `rsp_done`, output, 1 bit: 1-cycle end-of-job pulse.
REQ-019 The block SHALL have the port `rsp_fail`, output, 2 bits: completion status, valid with `rsp_done`; 00 = ok, 01 = not_valid, 10 = timeout.
REQ-020 The block SHALL have the port `rsp_len`, output, 8 bits: number of coordinates forwarded, valid with `rsp_done`.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, WAIT, STREAM and DONE; all outputs SHALL be registered.
REQ-022 In IDLE with `req` != 0, the block SHALL take the following actions at the edge:
- select the winner by round-robin;
- set `grant` = onehot(winner) for exactly 1 cycle;
- capture the winner's maze into a 225-bit shift register;
- set `rsp_id` = winner, set the load counter to 0, and go to LOAD.
REQ-023 Round-robin: the priority pointer SHALL reset to 0; when both requests are high, the pointer index SHALL win; after any grant the pointer SHALL become the other index; when a single request is high, it SHALL win regardless of the pointer.
REQ-024 `req` SHALL be ignored outside IDLE; no grant SHALL be issued while busy.
REQ-025 In LOAD, `slv_in_valid` SHALL be 1 and `slv_maze` SHALL equal the shift-register bit 0 for exactly 225 consecutive cycles, starting the cycle after the grant, in order cell 0..224; the block SHALL then go to WAIT with `slv_in_valid` = 0 and the latency counter (12 bits) at 0.
REQ-026 In WAIT, the latency counter SHALL increment each cycle; transitions are:
- `slv_out_valid` = 1 -> go to STREAM and forward that coordinate;
- `slv_not_valid` = 1 -> go to DONE with `rsp_fail` = 01 and `rsp_len` = 0;
- 3000 consecutive WAIT cycles without either -> go to DONE with `rsp_fail` = 10 and `slv_rst` = 1 for 1 cycle.
REQ-027 If `slv_out_valid` and `slv_not_valid` are high in the same cycle, `slv_not_valid` SHALL win.
REQ-028 Forwarding: for every cycle with `slv_out_valid` = 1 in WAIT/STREAM, the next cycle SHALL have `rsp_valid` = 1, `rsp_x` = `slv_out_x` and `rsp_y` = `slv_out_y`; `rsp_len` SHALL increment, saturating at 255.
REQ-029 In STREAM, the first cycle with `slv_out_valid` = 0 SHALL go to DONE with `rsp_fail` = 00; the stream SHALL NOT resume.
REQ-030 DONE SHALL last 1 cycle with `rsp_done` = 1, then go to IDLE; a new grant SHALL be possible from the following cycle.
REQ-031 When `rsp_valid` = 0, `rsp_x`/`rsp_y` SHALL hold 0.

Reset
REQ-032 With `rst` high at an edge, including mid-job, the block SHALL take the following actions:
- go to IDLE;
- clear `grant`, `busy`, `slv_in_valid`, `slv_maze`, `rsp_valid`, `rsp_id`, `rsp_x`, `rsp_y`, `rsp_done`, `rsp_fail`, `rsp_len` and all counters;
- set the RR pointer to 0;
- set `slv_rst` = 1.
REQ-033 `slv_rst` SHALL fall the first cycle after `rst` is released; the aborted job SHALL produce no `rsp_done`.

Verification
REQ-034 The bench SHALL cover `req` = 01 with a solvable maze -> `grant` = 01 one cycle, 225 `slv_in_valid` cycles carrying `maze0` bits in order, the path forwarded with 1-cycle delay, then `rsp_done` with `rsp_fail` = 00 and `rsp_len` = path length.
REQ-035 The bench SHALL cover `req` = 11 from reset -> `grant` = 01; `req` held, after `rsp_done` -> `grant` = 10 and `rsp_id` = 1.
REQ-036 The bench SHALL cover a solver pulsing `slv_not_valid` 10 cycles into WAIT -> `rsp_done` with `rsp_fail` = 01, `rsp_len` = 0, next cycle IDLE.
REQ-037 The bench SHALL cover a silent solver -> after exactly 3000 WAIT cycles, `rsp_fail` = 10, `slv_rst` pulses 1 cycle, and `busy` falls one cycle later.
REQ-038 The bench SHALL cover `rst` asserted at LOAD cycle 100 -> next cycle `slv_in_valid` = 0, `busy` = 0, `slv_rst` = 1, no `rsp_done`; a fresh request afterwards restarts from cell 0.

Source files
------------

// File: rtl/maze_sched.sv
// maze_sched -- schedules maze-solving jobs from two requesters onto one
// shared serial solver.
//
// A job is accepted in IDLE (round-robin between the two requesters), its
// 225-cell maze is shifted out to the solver one bit per cycle, and the
// solver's path coordinates are forwarded to the response port one cycle
// later. A job ends with a one-cycle rsp_done pulse carrying the status
// (ok / no path / timeout) and the number of forwarded coordinates.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   req[1:0]                : per-requester job request (held until granted)
//   maze0, maze1 [224:0]    : requester mazes, bit y*15+x = cell (x,y), 1 = wall
//   grant[1:0]              : one-hot, one-cycle job-accepted pulse
//   busy                    : high whenever not IDLE
//   slv_rst                 : reset request to the solver
//   slv_in_valid, slv_maze  : serial maze stream to the solver
//   slv_out_valid, slv_not_valid, slv_out_x, slv_out_y : solver results
//   rsp_valid, rsp_id, rsp_x, rsp_y : forwarded path coordinates
//   rsp_done, rsp_fail, rsp_len     : end-of-job pulse, status, path length
module maze_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [224:0] maze0,
  input  logic [224:0] maze1,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         slv_rst,
  output logic         slv_in_valid,
  output logic         slv_maze,
  input  logic         slv_out_valid,
  input  logic         slv_not_valid,
  input  logic [3:0]   slv_out_x,
  input  logic [3:0]   slv_out_y,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [3:0]   rsp_x,
  output logic [3:0]   rsp_y,
  output logic         rsp_done,
  output logic [1:0]   rsp_fail,
  output logic [7:0]   rsp_len
);

  localparam logic [7:0]  LOAD_CELLS   = 8'd225;
  // Last WAIT cycle index before timing out (3000 cycles: 0..2999).
  localparam logic [11:0] WAIT_LAST    = 12'd2999;
  localparam logic [1:0]  FAIL_OK      = 2'b00;
  localparam logic [1:0]  FAIL_NOPATH  = 2'b01;
  localparam logic [1:0]  FAIL_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic [224:0]   shreg_q, shreg_d;
  logic [7:0]     load_cnt_q, load_cnt_d;
  logic [11:0]    lat_cnt_q, lat_cnt_d;
  logic [1:0]     grant_q, grant_d;
  logic           busy_q, busy_d;
  logic           slv_rst_q, slv_rst_d;
  logic           slv_in_valid_q, slv_in_valid_d;
  logic           slv_maze_q, slv_maze_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [3:0]     rsp_x_q, rsp_x_d;
  logic [3:0]     rsp_y_q, rsp_y_d;
  logic           rsp_done_q, rsp_done_d;
  logic [1:0]     rsp_fail_q, rsp_fail_d;
  logic [7:0]     rsp_len_q, rsp_len_d;
  logic           winner_s;

  // Saturating increment of the path-length counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc = 8'hFF;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    shreg_d        = shreg_q;
    load_cnt_d     = load_cnt_q;
    lat_cnt_d      = lat_cnt_q;
    grant_d        = 2'b00;
    slv_rst_d      = 1'b0;
    slv_in_valid_d = 1'b0;
    slv_maze_d     = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_x_d        = 4'd0;
    rsp_y_d        = 4'd0;
    rsp_id_d       = rsp_id_q;
    rsp_done_d     = 1'b0;
    rsp_fail_d     = rsp_fail_q;
    rsp_len_d      = rsp_len_q;
    // Both requesting: pointer wins; otherwise the lone requester wins.
    winner_s       = (req == 2'b11) ? rr_q : req[1];

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_d    = winner_s ? 2'b10 : 2'b01;
          shreg_d    = winner_s ? maze1 : maze0;
          rsp_id_d   = winner_s;
          rr_d       = ~winner_s;
          load_cnt_d = 8'd0;
          lat_cnt_d  = 12'd0;
          rsp_len_d  = 8'd0;
          rsp_fail_d = FAIL_OK;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        // Cell 0 first: the register shifts right, bit 0 is always next.
        if (load_cnt_q == LOAD_CELLS) begin
          lat_cnt_d = 12'd0;
          state_d   = S_WAIT;
        end else begin
          slv_in_valid_d = 1'b1;
          slv_maze_d     = shreg_q[0];
          shreg_d        = {1'b0, shreg_q[224:1]};
          load_cnt_d     = load_cnt_q + 8'd1;
        end
      end

      S_WAIT: begin
        lat_cnt_d = lat_cnt_q + 12'd1;
        // "No path" takes precedence over a coincident coordinate.
        if (slv_not_valid) begin
          rsp_done_d = 1'b1;
          rsp_fail_d = FAIL_NOPATH;
          rsp_len_d  = 8'd0;
          state_d    = S_DONE;
        end else if (slv_out_valid) begin
          rsp_valid_d = 1'b1;
          rsp_x_d     = slv_out_x;
          rsp_y_d     = slv_out_y;
          rsp_len_d   = sat_inc(rsp_len_q);
          state_d     = S_STREAM;
        end else if (lat_cnt_q == WAIT_LAST) begin
          rsp_done_d = 1'b1;
          rsp_fail_d = FAIL_TIMEOUT;
          slv_rst_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_STREAM: begin
        if (slv_not_valid) begin
          rsp_done_d = 1'b1;
          rsp_fail_d = FAIL_NOPATH;
          state_d    = S_DONE;
        end else if (slv_out_valid) begin
          rsp_valid_d = 1'b1;
          rsp_x_d     = slv_out_x;
          rsp_y_d     = slv_out_y;
          rsp_len_d   = sat_inc(rsp_len_q);
          state_d     = S_STREAM;
        end else begin
          // First gap ends the path; the stream never resumes.
          rsp_done_d = 1'b1;
          rsp_fail_d = FAIL_OK;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_q           <= 1'b0;
      shreg_q        <= '0;
      load_cnt_q     <= 8'd0;
      lat_cnt_q      <= 12'd0;
      grant_q        <= 2'b00;
      busy_q         <= 1'b0;
      slv_rst_q      <= 1'b1;
      slv_in_valid_q <= 1'b0;
      slv_maze_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_x_q        <= 4'd0;
      rsp_y_q        <= 4'd0;
      rsp_done_q     <= 1'b0;
      rsp_fail_q     <= 2'b00;
      rsp_len_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      shreg_q        <= shreg_d;
      load_cnt_q     <= load_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      slv_rst_q      <= slv_rst_d;
      slv_in_valid_q <= slv_in_valid_d;
      slv_maze_q     <= slv_maze_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_x_q        <= rsp_x_d;
      rsp_y_q        <= rsp_y_d;
      rsp_done_q     <= rsp_done_d;
      rsp_fail_q     <= rsp_fail_d;
      rsp_len_q      <= rsp_len_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign slv_rst      = slv_rst_q;
  assign slv_in_valid = slv_in_valid_q;
  assign slv_maze     = slv_maze_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_x        = rsp_x_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_done     = rsp_done_q;
  assign rsp_fail     = rsp_fail_q;
  assign rsp_len      = rsp_len_q;

endmodule
